// File: rtl/multiplier_batch_control_pkg.sv
// Shared constants, FSM state type and the combinational fp32 multiply
// evaluated in the first stage of the shared multiplier core.
`ifndef MBC_GLOBALS_DEFINED
`define MBC_GLOBALS_DEFINED
`define SINGLE 32
`define MUL_LATENCY 5
`define ENA_MATH 1
`endif

package multiplier_batch_control_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic int tag_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-to-nearest-even single multiply; subnormal inputs and results flush to zero.
  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic               sign;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]        prod;
    logic [22:0]        mant;
    logic               guard, sticky;
    logic signed [9:0]  e_sum;
    logic [30:0]        mag;
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e_sum  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      e_sum  = e_sum + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    // A rounding carry out of the mantissa ripples into the exponent field.
    mag = {e_sum[7:0], mant};
    if (guard && (sticky || mant[0])) begin
      mag = mag + 31'd1;
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      return QNAN;
    end
    if (a_inf || b_inf) begin
      return {sign, 8'hFF, 23'd0};
    end
    if (a_zero || b_zero) begin
      return {sign, 31'd0};
    end
    if (e_sum >= 10'sd255) begin
      return {sign, 8'hFF, 23'd0};
    end
    if (e_sum <= 10'sd0) begin
      return {sign, 31'd0};
    end
    return {sign, mag};
  endfunction

endpackage

// File: rtl/multiplier_batch_control_mul_tag_pipe.sv
// Pipelined fp32 multiplier core with a matching {valid, tag} shift register,
// so results come out labelled with the tag they were issued under.
module mul_tag_pipe
  import multiplier_batch_control_pkg::*;
#(
  parameter int WIDTH   = `SINGLE,
  parameter int LATENCY = `MUL_LATENCY,
  parameter int TAG_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic clr;
  assign clr = ~rst;

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic [TAG_W-1:0] tag_reg;

    if (gi == 0) begin : g_head
      // The arithmetic happens here; later stages only carry it along.
      always_ff @(posedge clk) begin
        if (clr) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
          tag_reg   <= '0;
        end else begin
          data_reg  <= fp32_mul(a, b);
          valid_reg <= in_valid;
          tag_reg   <= in_tag;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (clr) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
          tag_reg   <= '0;
        end else begin
          data_reg  <= g_stage[gi-1].data_reg;
          valid_reg <= g_stage[gi-1].valid_reg;
          tag_reg   <= g_stage[gi-1].tag_reg;
        end
      end
    end
  end

  assign result    = g_stage[LATENCY-1].data_reg;
  assign out_valid = g_stage[LATENCY-1].valid_reg;
  assign out_tag   = g_stage[LATENCY-1].tag_reg;

endmodule

// File: rtl/multiplier_batch_control.sv
// Batch controller: snapshots N_CH operand pairs on sta, streams them through one
// shared multiplier, gathers results by tag and publishes the vector with done_sig.
module multiplier_batch_control
  import multiplier_batch_control_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = `SINGLE,
  parameter int LATENCY = `MUL_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sta,
  input  logic                  mode,
  input  logic [N_CH*WIDTH-1:0] x_bus,
  input  logic [N_CH*WIDTH-1:0] y_bus,
  output logic [N_CH*WIDTH-1:0] xy_bus,
  output logic                  done_sig,
  output logic                  busy,
  output logic                  sta_drop
);

  localparam int TAG_W = tag_bits(N_CH);
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(N_CH - 1);

  state_t                       state_reg, state_next;
  logic [TAG_W-1:0]             cnt_reg, cnt_next;
  logic                         mode_reg;
  logic [N_CH-1:0][WIDTH-1:0]   x_snap_reg, y_snap_reg;
  logic [N_CH-1:0][WIDTH-1:0]   staging_reg;
  logic [N_CH-1:0][WIDTH-1:0]   xy_reg;
  logic                         done_reg, busy_reg, drop_reg;

  logic                         accept, issue_valid, finish;
  logic [WIDTH-1:0]             issue_x, issue_y;
  logic [WIDTH-1:0]             core_result;
  logic                         core_valid;
  logic [TAG_W-1:0]             core_tag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    issue_valid = 1'b0;
    finish      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sta) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (cnt_reg == LAST_TAG) begin
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        // Tags return in issue order, so the last channel's result closes the batch.
        if (core_valid && core_tag == LAST_TAG) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue_x = '0;
    issue_y = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_reg == TAG_W'(i)) begin
        issue_x = x_snap_reg[i];
        issue_y = y_snap_reg[i];
      end
    end
    if (mode_reg) begin
      issue_y = y_snap_reg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_snap_reg <= '0;
      y_snap_reg <= '0;
      mode_reg   <= 1'b0;
    end else if (accept) begin
      x_snap_reg <= x_bus;
      y_snap_reg <= y_bus;
      mode_reg   <= mode;
    end
  end

  mul_tag_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_mul_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .a         (issue_x),
    .b         (issue_y),
    .in_valid  (issue_valid),
    .in_tag    (cnt_reg),
    .result    (core_result),
    .out_valid (core_valid),
    .out_tag   (core_tag)
  );

  // The final result bypasses staging so the whole vector publishes in one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      staging_reg <= '0;
      xy_reg      <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (core_valid && core_tag == TAG_W'(i)) begin
          staging_reg[i] <= core_result;
        end
      end
      if (finish) begin
        for (int i = 0; i < N_CH; i++) begin
          xy_reg[i] <= (core_tag == TAG_W'(i)) ? core_result : staging_reg[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
      drop_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      busy_reg <= (state_next != IDLE);
      drop_reg <= sta && (state_reg != IDLE);
    end
  end

  assign xy_bus   = xy_reg;
  assign done_sig = done_reg;
  assign busy     = busy_reg;
  assign sta_drop = drop_reg;

endmodule

// File: tb/tb_multiplier_batch_control.sv
// Bench for multiplier_batch_control: cycle-level batch model plus directed literals.
module tb_multiplier_batch_control;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 5;

  localparam logic [N*W-1:0] X_A      = {32'h40400000, 32'hBF000000, 32'h40000000, 32'h3FC00000};
  localparam logic [N*W-1:0] Y_A      = {32'h00000000, 32'h40800000, 32'h40000000, 32'h40000000};
  localparam logic [N*W-1:0] Y_SCALE  = {32'h12345678, 32'h0BADF00D, 32'h7F7FFFFF, 32'h40000000};
  localparam logic [N*W-1:0] X_B      = {32'hBF800000, 32'h3F800000, 32'h40800000, 32'h40000000};
  localparam logic [N*W-1:0] Y_B      = {32'h40000000, 32'h41000000, 32'h3E800000, 32'h3F000000};
  localparam logic [N*W-1:0] LIT_PAIR = {32'h00000000, 32'hC0000000, 32'h40800000, 32'h40400000};
  localparam logic [N*W-1:0] LIT_SCL  = {32'h40C00000, 32'hBF800000, 32'h40800000, 32'h40400000};
  localparam logic [N*W-1:0] LIT_B    = {32'hC0000000, 32'h41000000, 32'h3F800000, 32'h3F800000};
  localparam logic [N*W-1:0] GARBAGE  = {32'hDEADBEEF, 32'h01234567, 32'h7F000001, 32'hC1F00000};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           sta = 1'b0;
  logic           mode = 1'b0;
  logic [N*W-1:0] x_bus = '0;
  logic [N*W-1:0] y_bus = '0;
  logic [N*W-1:0] xy_bus;
  logic           done_sig, busy, sta_drop;

  logic           sta1 = 1'b0;
  logic [W-1:0]   x1 = '0;
  logic [W-1:0]   y1 = '0;
  logic [W-1:0]   xy1;
  logic           done1, busy1, drop1;

  always #5 clk = ~clk;

  multiplier_batch_control #(.N_CH(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .sta(sta), .mode(mode), .x_bus(x_bus), .y_bus(y_bus),
    .xy_bus(xy_bus), .done_sig(done_sig), .busy(busy), .sta_drop(sta_drop)
  );

  multiplier_batch_control #(.N_CH(1), .WIDTH(W), .LATENCY(L)) dut1 (
    .clk(clk), .rst(rst), .sta(sta1), .mode(1'b0), .x_bus(x1), .y_bus(y1),
    .xy_bus(xy1), .done_sig(done1), .busy(busy1), .sta_drop(drop1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Exact fp32 <-> real conversion through the double format (normal values and zero only).
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] de;
    if (f[30:23] == 8'd0) return 0.0;
    de = {3'd0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], de, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Model: a batch accepted at an edge publishes N+L edges later; sta while busy is dropped.
  bit             m_busy = 1'b0;
  int             m_rem = 0;
  bit             m_done = 1'b0;
  bit             m_drop = 1'b0;
  logic [N*W-1:0] m_xy = '0;
  logic [N*W-1:0] m_pend = '0;

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    m_drop = 1'b0;
    if (!rst) begin
      m_busy = 1'b0;
      m_xy   = '0;
    end else if (m_busy) begin
      if (sta) m_drop = 1'b1;
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_busy = 1'b0;
        m_xy   = m_pend;
      end
    end else if (sta) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i*W +: W] = r2f(f2r(x_bus[i*W +: W]) *
                               f2r(mode ? y_bus[W-1:0] : y_bus[i*W +: W]));
      end
      m_rem  = N + L;
      m_busy = 1'b1;
    end
  end

  int done_count = 0;
  int last_done = -1;
  int drop_count = 0;
  int last_drop = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("done_sig", {127'd0, done_sig}, {127'd0, m_done});
      check("busy", {127'd0, busy}, {127'd0, m_busy});
      check("sta_drop", {127'd0, sta_drop}, {127'd0, m_drop});
      check("xy_bus", xy_bus, m_xy);
      if (done_sig) begin
        done_count++;
        last_done = cyc;
      end
      if (sta_drop) begin
        drop_count++;
        last_drop = cyc;
      end
    end
  end

  task automatic pulse_sta(output int t);
    @(posedge clk); #1;
    sta = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    sta = 1'b0;
  endtask

  initial begin
    int t, t2, dc, dr, d1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_xy", xy_bus, '0);
    check("reset_busy", {127'd0, busy}, '0);
    check("reset_done", {127'd0, done_sig}, '0);
    check("reset_xy1", {96'd0, xy1}, '0);

    // Pairwise batch; operands scrambled right after sta to exercise the snapshot.
    x_bus = X_A; y_bus = Y_A; mode = 1'b0;
    dc = done_count;
    pulse_sta(t);
    x_bus = GARBAGE; y_bus = GARBAGE;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("pair_done_time", 128'(last_done), 128'(t + 10));
    check("pair_done_count", 128'(done_count), 128'(dc + 1));
    check("pair_xy", xy_bus, LIT_PAIR);
    $display("txn pair: sta@%0d done@%0d xy=%h", t, last_done, xy_bus);

    // Scale mode: only y[0] matters.
    x_bus = X_A; y_bus = Y_SCALE; mode = 1'b1;
    pulse_sta(t);
    mode = 1'b0; x_bus = GARBAGE;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("scale_done_time", 128'(last_done), 128'(t + 10));
    check("scale_xy", xy_bus, LIT_SCL);
    $display("txn scale: sta@%0d done@%0d xy=%h", t, last_done, xy_bus);

    // Overrun: second sta at t+3 is dropped.
    x_bus = X_A; y_bus = Y_A;
    dc = done_count; dr = drop_count;
    pulse_sta(t);
    repeat (2) @(posedge clk);
    #1;
    x_bus = X_B; y_bus = Y_B; sta = 1'b1;
    @(posedge clk); #1;
    sta = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("ovr_drop_time", 128'(last_drop), 128'(t + 4));
    check("ovr_drop_count", 128'(drop_count), 128'(dr + 1));
    check("ovr_done_count", 128'(done_count), 128'(dc + 1));
    check("ovr_done_time", 128'(last_done), 128'(t + 10));
    check("ovr_xy", xy_bus, LIT_PAIR);
    $display("txn overrun: sta@%0d drop@%0d done@%0d xy=%h", t, last_drop, last_done, xy_bus);

    // Back-to-back: new sta in the done_sig cycle of the previous batch.
    x_bus = X_A; y_bus = Y_SCALE; mode = 1'b1;
    dc = done_count; dr = drop_count;
    pulse_sta(t);
    mode = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    x_bus = X_B; y_bus = Y_B; sta = 1'b1;
    t2 = cyc;
    @(posedge clk); #1;
    sta = 1'b0;
    x_bus = GARBAGE; y_bus = GARBAGE;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("b2b_hold_xy", xy_bus, LIT_SCL);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b_first_done", 128'(t2), 128'(t + 10));
    check("b2b_done_time", 128'(last_done), 128'(t2 + 10));
    check("b2b_done_count", 128'(done_count), 128'(dc + 2));
    check("b2b_no_drop", 128'(drop_count), 128'(dr));
    check("b2b_xy", xy_bus, LIT_B);
    $display("txn b2b: sta@%0d sta2@%0d done@%0d xy=%h", t, t2, last_done, xy_bus);

    // Mid-batch reset at t+6 aborts the batch and clears the published vector.
    x_bus = X_A; y_bus = Y_A;
    dc = done_count;
    pulse_sta(t);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_no_done", 128'(done_count), 128'(dc));
    check("rst_xy", xy_bus, '0);
    check("rst_busy", {127'd0, busy}, '0);
    x_bus = X_B; y_bus = Y_B;
    pulse_sta(t);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("rst_after_done", 128'(last_done), 128'(t + 10));
    check("rst_after_count", 128'(done_count), 128'(dc + 1));
    check("rst_after_xy", xy_bus, LIT_B);
    $display("txn post-reset: sta@%0d done@%0d xy=%h", t, last_done, xy_bus);

    // Single-channel instance: 1.5 * -2.0, done at t+7.
    x1 = 32'h3FC00000; y1 = 32'hC0000000;
    @(posedge clk); #1;
    sta1 = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    sta1 = 1'b0;
    x1 = 32'h7F000001; y1 = 32'h12345678;
    d1 = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done1 && d1 < 0) d1 = cyc;
    end
    check("n1_done_time", 128'(d1), 128'(t + 7));
    check("n1_xy", {96'd0, xy1}, {96'd0, 32'hC0400000});
    check("n1_busy", {127'd0, busy1}, '0);
    $display("txn n1: sta@%0d done@%0d xy=%h", t, d1, xy1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_batch_control.md
Name: multiplier_batch_control

Overview:
- Time-multiplexed batch controller for one shared single-precision floating-point multiplier core.
- A single `sta` pulse snapshots N_CH operand pairs and issues one pair per cycle into the pipelined core.
- Results are collected by channel tag, and the full result vector is published coherently with a one-cycle `done_sig`.
- Used in the OPT datapath wherever several per-channel products are needed per solver step without spending one multiplier per channel.

Parameters:
- N_CH, 4: number of channels per batch (1..16).
- WIDTH, `SINGLE (32): operand and result width.
- LATENCY, 5: multiplier core latency in cycles, from operand presentation to valid result.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- sta  in  1  batch start pulse.
- mode  in  1  0 = pairwise x[i]*y[i]; 1 = scale, x[i]*y[0] for all i.
- x_bus  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- y_bus  in  N_CH*WIDTH  same packing as x_bus.
- xy_bus  out  N_CH*WIDTH  published products.
- done_sig  out  1  one-cycle pulse; xy_bus is valid from this cycle onward.
- busy  out  1  batch in flight.
- sta_drop  out  1  one-cycle pulse when sta is rejected.

Behaviour:
- Reset (rst==0 at a clk edge): xy_bus=0, done_sig=0, busy=0, sta_drop=0, FSM=IDLE.
  - Issue counter, tag pipe and staging registers are cleared.
  - The core's clear input is driven from ~rst.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - When sta=1, latch x_bus, y_bus and mode into snapshot registers, set busy=1, go to ISSUE with issue counter = 0.
  - Inputs changing after the sta cycle have no effect on the batch.
- ISSUE:
  - Each cycle, present snapshot operands for channel = counter. In mode 1, y is y[0].
  - Push {valid=1, tag=counter} into a LATENCY-deep tag shift register; increment the counter.
  - After channel N_CH-1 is issued, go to DRAIN.
- Tag pipe: when the tag emerging from the pipe is valid, write the core result into staging[tag].
- DRAIN:
  - When the last tag (N_CH-1) is written, copy staging to xy_bus on the next edge.
  - In that same cycle, pulse done_sig=1 and drop busy=0, then return to IDLE.
- Timing:
  - sta sampled in cycle t; channel i is presented in cycle t+1+i.
  - Its result is valid in cycle t+1+i+LATENCY.
  - done_sig is high in cycle t+N_CH+LATENCY+1. For the defaults that is t+10.
- Output hold: xy_bus holds the previous batch's values until the next done_sig. There is no partial update.
- sta while busy=1: ignored with no queuing; sta_drop pulses in the following cycle.
- sta in the done_sig cycle: busy is already 0, so the new batch is accepted. The back-to-back issue period is N_CH+LATENCY+1 cycles.
- Reset mid-batch: the batch is aborted, no done_sig is produced, xy_bus returns to 0, and in-flight core results are discarded because the tag pipe is cleared.
- Arithmetic:
  - IEEE-754 single behaviour is whatever the core produces; this block adds no rounding or exception handling.
  - Width is exactly WIDTH; no truncation or extension.
- Tag width is clog2(N_CH), minimum 1 bit.

Decomposition:
- Shared global parameter include holds `SINGLE, a new `MUL_LATENCY constant (5) and the existing `ena_math.
- One sub-module: mul_tag_pipe.
  - Wraps the multiplier core plus the LATENCY-deep {valid, tag} shift register.
  - Input side: operands + in_valid + in_tag. Output side: result + out_valid + out_tag.
  - Reusable by other time-multiplexed arithmetic controllers.

Test Plan:
- Pairwise batch (defaults, mode=0): x={1.5,2.0,-0.5,3.0}, y={2.0,2.0,4.0,0.0}, sta at t.
  - done_sig exactly at t+10.
  - xy={0x40400000, 0x40800000, 0xC0000000, 0x00000000}.
  - busy high over t+1..t+9.
- Scale mode: same x, y[0]=2.0, y[1..3]=garbage, mode=1.
  - xy={0x40400000, 0x40800000, 0xBF800000, 0x40C00000}.
- Overrun: sta at t and t+3.
  - Exactly one done_sig, at t+10.
  - sta_drop pulses at t+4.
  - Results match the first batch.
- Back-to-back: second sta asserted in the done_sig cycle of batch 1 with new operands.
  - Accepted, no sta_drop.
  - Second done_sig 10 cycles later.
  - xy_bus holds batch-1 values until then.
- Mid-batch reset: rst=0 for one cycle at t+6.
  - No done_sig.
  - xy_bus=0, busy=0.
  - A subsequent sta completes a correct batch with no stale-tag writes.
- Snapshot: change x_bus and y_bus at t+1 after sta at t.
  - Results reflect the values sampled at t only.
  - Repeat with N_CH=1, LATENCY=5: done_sig at t+7.
